// File: rtl/instruction_fetcher_pkg.sv
// Shared fetch-stage types: FSM encoding, queue entry layout, JAL decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package instruction_fetcher_pkg;

  // Major opcode of JAL; every other opcode falls through to pc+4.
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Sequential step between instruction words.
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fifo_ent_t;

  // Sign-extended J-type immediate: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Static prediction: JAL is followed, branches are not-taken, JALR falls through.
  function automatic logic [31:0] calc_next_pc(input logic [31:0] pc,
                                               input logic [31:0] inst);
    if (inst[6:0] == OP_JAL) begin
      return pc + j_imm(inst);
    end
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bundles the memory-controller fetch port and the decoder issue port.
// Latency: n/a (wires only).
// Backpressure: fetch is a level request held until finish_fetch; issue is valid/ready.
interface instruction_fetcher_if;

  // fetch side, towards the memory controller
  logic        fetch_start;
  logic [31:0] pc;
  logic        finish_fetch;
  logic [31:0] instruction_in;
  logic [31:0] instruction_pc_in;

  // issue side, towards the decoder
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic        issue_ready;

  // The fetcher drives requests and the queue head.
  modport master (
    output fetch_start, pc, issue_valid, issue_inst, issue_pc,
    input  finish_fetch, instruction_in, instruction_pc_in, issue_ready
  );

  // Controller and decoder side.
  modport slave (
    input  fetch_start, pc, issue_valid, issue_inst, issue_pc,
    output finish_fetch, instruction_in, instruction_pc_in, issue_ready
  );

endinterface

// File: rtl/instruction_fetcher_inst_fifo.sv
// Circular instruction queue of {pc, inst} entries with occupancy count and full flag.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: producer must check count/full before pushing; pop on an empty queue is ignored.
module instruction_fetcher_inst_fifo
  import instruction_fetcher_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clr,
  input  logic                   push_vld,
  input  fifo_ent_t              push_dat,
  input  logic                   pop_vld,
  output fifo_ent_t              head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_ent_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  assign pop_ok   = pop_vld && (count_q != '0);
  assign head_dat = mem_q[head_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));

  // Entry storage needs no reset: count gates whether the head is meaningful.
  always_ff @(posedge clk_in) begin
    if (push_vld && !clr) begin
      mem_q[tail_q] <= push_dat;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy, unchanged on push+pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_vld) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop_ok) begin
        head_q <= head_q + 1'b1;
      end
      case ({push_vld, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Sequential instruction fetcher: one outstanding request, JAL followed, branches not-taken.
// Latency: request visible 1 cycle after IDLE; fetched word at queue head 1 cycle after finish_fetch.
// Backpressure: no request is issued unless the queue has room for the in-flight word; rdy_in low freezes all state.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         roll_back,
  input  logic [31:0]                  roll_back_pc,
  output logic                         queue_full,
  instruction_fetcher_if.master        fetch_bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic             fetch_start_q, fetch_start_d;
  logic [31:0]      pc_q, pc_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clr;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fifo_ent_t        push_dat;
  fifo_ent_t        head_dat;
  logic             issue_vld;
  logic             room_vld;

  // Room for one more word means the in-flight fetch can always be accepted.
  assign room_vld  = (fifo_count < CNT_W'(QUEUE_DEPTH));
  assign issue_vld = (fifo_count != '0);
  assign push_dat  = '{pc: fetch_bus.instruction_pc_in, inst: fetch_bus.instruction_in};

  assign fetch_bus.fetch_start = fetch_start_q;
  assign fetch_bus.pc          = pc_q;
  assign fetch_bus.issue_valid = issue_vld;
  assign fetch_bus.issue_inst  = head_dat.inst;
  assign fetch_bus.issue_pc    = head_dat.pc;
  assign queue_full            = fifo_full;

  // FSM state, request level and fetch address; all change only while rdy_in is high.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      fetch_start_q <= 1'b0;
      pc_q          <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_start_q <= fetch_start_d;
      pc_q          <= pc_d;
    end
  end

  // Next state and queue control; roll_back overrides any finish or pop in the same cycle.
  always_comb begin
    state_d       = state_q;
    fetch_start_d = fetch_start_q;
    pc_d          = pc_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_clr      = 1'b0;
    if (rdy_in) begin
      if (roll_back) begin
        fifo_clr      = 1'b1;
        pc_d          = roll_back_pc;
        fetch_start_d = 1'b0;
        state_d       = ST_IDLE;
      end else begin
        fifo_pop = issue_vld && fetch_bus.issue_ready;
        unique case (state_q)
          ST_IDLE: begin
            // A finish_fetch seen here is stale and deliberately ignored.
            if (room_vld) begin
              state_d       = ST_WAIT;
              fetch_start_d = 1'b1;
            end
          end
          ST_WAIT: begin
            // pc stays put until the word arrives; the controller reads it combinationally.
            if (fetch_bus.finish_fetch) begin
              fifo_push     = 1'b1;
              fetch_start_d = 1'b0;
              pc_d          = calc_next_pc(pc_q, fetch_bus.instruction_in);
              state_d       = ST_IDLE;
            end
          end
          default: begin
            state_d       = ST_IDLE;
            fetch_start_d = 1'b0;
          end
        endcase
      end
    end
  end

  instruction_fetcher_inst_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr      (fifo_clr),
    .push_vld (fifo_push),
    .push_dat (push_dat),
    .pop_vld  (fifo_pop),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized bench for instruction_fetcher against a queue-based reference model.
// Latency: checks every cycle on the falling edge, inputs applied on the same falling edge.
// Backpressure: exercises rdy_in pauses, decoder stalls, full queue and roll_back.
module tb_instruction_fetcher;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic [31:0] roll_back_pc;
  logic        queue_full;

  instruction_fetcher_if bus();

  instruction_fetcher #(
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .roll_back    (roll_back),
    .roll_back_pc (roll_back_pc),
    .queue_full   (queue_full),
    .fetch_bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks;
  int n_errors;

  // reference model state
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_req;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] issued[$];

  // stimulus knobs and controller model
  int k_rdy_pct, k_pop_pct, k_rb_permil, k_stale_pct;
  bit pause_req, rb_on_fin, rb_hit, ctl_armed, prev_req;
  int pause_left, ctl_lat, n_pauses, n_reqs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return NOP;
  endfunction

  // Target of the fetched word computed from the J-immediate fields by plain arithmetic.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [31:0] inst);
    int imm;
    if (inst[6:0] != 7'h6f) return pc + 32'd4;
    imm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096;
    if (inst[31]) imm = imm - (1 << 20);
    return pc + 32'(imm);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc       = RST_PC;
    m_req      = 1'b0;
    ctl_armed  = 1'b0;
    pause_left = 0;
    prev_req   = 1'b0;
  endtask

  // Compare outputs, choose the inputs for the next edge, then advance the model past it.
  task automatic cycle();
    logic        rdy, rb, pop_rdy, fin, room;
    logic [31:0] rbpc, inst, ipc;

    check("fetch_start", 32'(bus.fetch_start), 32'(m_req));
    check("pc", bus.pc, m_pc);
    check("issue_valid", 32'(bus.issue_valid), 32'(m_q.size() != 0));
    check("queue_full", 32'(queue_full), 32'(m_q.size() == DEPTH));
    if (m_q.size() != 0) begin
      check("issue_pc", bus.issue_pc, m_q[0].pc);
      check("issue_inst", bus.issue_inst, m_q[0].inst);
    end
    if (bus.fetch_start && !prev_req) n_reqs++;
    prev_req = bus.fetch_start;

    if (pause_req && m_req) begin
      pause_req  = 1'b0;
      pause_left = 5;
      n_pauses++;
    end
    rdy = (pause_left == 0) && ($urandom_range(99) < k_rdy_pct);
    if (pause_left > 0) pause_left--;
    pop_rdy = ($urandom_range(99) < k_pop_pct);
    rb      = rdy && ($urandom_range(999) < k_rb_permil);
    rbpc    = 32'h2000 + 4 * $urandom_range(511);

    fin  = 1'b0;
    inst = $urandom;
    ipc  = $urandom;
    if (m_req && !ctl_armed) begin
      ctl_armed = 1'b1;
      ctl_lat   = $urandom_range(3);
    end
    if (!rdy) begin
      // finish_fetch is driven while paused; the fetcher must ignore it
      fin = 1'b1;
      if (m_req) begin
        inst = mem_rd(m_pc);
        ipc  = m_pc;
      end
    end else if (m_req) begin
      if (ctl_lat == 0) begin
        fin  = 1'b1;
        inst = mem_rd(m_pc);
        ipc  = m_pc;
      end else begin
        ctl_lat--;
      end
    end else begin
      fin = ($urandom_range(99) < k_stale_pct);
    end
    if (rb_on_fin && rdy && m_req && fin) begin
      rb        = 1'b1;
      rbpc      = 32'h1000;
      pop_rdy   = 1'b1;
      rb_on_fin = 1'b0;
      rb_hit    = 1'b1;
    end

    rdy_in                = rdy;
    roll_back             = rb;
    roll_back_pc          = rbpc;
    bus.issue_ready       = pop_rdy;
    bus.finish_fetch      = fin;
    bus.instruction_in    = inst;
    bus.instruction_pc_in = ipc;

    if (rdy && !rb && pop_rdy && bus.issue_valid) issued.push_back(bus.issue_pc);
    if (rdy && !rb && fin && bus.fetch_start) check("push_room", 32'(queue_full), 32'(0));

    if (rdy) begin
      if (rb) begin
        m_q.delete();
        m_pc      = rbpc;
        m_req     = 1'b0;
        ctl_armed = 1'b0;
      end else begin
        room = (m_q.size() < DEPTH);
        if (pop_rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (m_req) begin
          if (fin) begin
            m_q.push_back('{pc: ipc, inst: inst});
            m_pc      = ref_next_pc(m_pc, inst);
            m_req     = 1'b0;
            ctl_armed = 1'b0;
          end
        end else if (room) begin
          m_req = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    cycle();
  endtask

  logic [31:0] exp_seq [7];
  int          r0;
  int          rnd;
  logic [31:0] w;
  bit          found;

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pauses = 0;
    n_reqs   = 0;
    exp_seq  = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h20, 32'h24};
    rst_in                = 1'b0;
    rdy_in                = 1'b0;
    roll_back             = 1'b0;
    roll_back_pc          = 32'h0;
    bus.finish_fetch      = 1'b0;
    bus.instruction_in    = 32'h0;
    bus.instruction_pc_in = 32'h0;
    bus.issue_ready       = 1'b0;
    k_rdy_pct   = 100;
    k_pop_pct   = 100;
    k_rb_permil = 0;
    k_stale_pct = 0;
    pause_req   = 1'b0;
    rb_on_fin   = 1'b0;
    rb_hit      = 1'b0;
    ctl_lat     = 0;
    model_reset();
    mem[32'h10] = 32'h0100006F;

    // reset values
    repeat (3) @(negedge clk_in);
    check("rst_fetch_start", 32'(bus.fetch_start), 32'(0));
    check("rst_pc", bus.pc, RST_PC);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'(0));
    check("rst_queue_full", 32'(queue_full), 32'(0));
    rst_in = 1'b1;
    cycle();

    // NOP stream with a JAL at 0x10, decoder always ready
    issued.delete();
    for (int i = 0; i < 300 && issued.size() < 7; i++) step();
    check("seq_len", 32'(issued.size()), 32'd7);
    for (int i = 0; i < 7 && i < issued.size(); i++) check("seq_pc", issued[i], exp_seq[i]);

    // decoder stalled: queue fills to exactly DEPTH and fetching stops
    k_pop_pct = 0;
    repeat (150) step();
    check("full_flag", 32'(queue_full), 32'd1);
    check("full_no_fetch", 32'(bus.fetch_start), 32'd0);
    r0 = n_reqs;
    k_pop_pct = 100;
    step();
    k_pop_pct = 0;
    repeat (20) step();
    check("refill_one", 32'(n_reqs - r0), 32'd1);
    check("refull_flag", 32'(queue_full), 32'd1);

    // roll_back coinciding with finish_fetch and issue_ready
    k_pop_pct = 50;
    rb_on_fin = 1'b1;
    rb_hit    = 1'b0;
    for (int i = 0; i < 200 && !rb_hit; i++) step();
    check("rb_hit", 32'(rb_hit), 32'd1);
    @(negedge clk_in);
    check("rb_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("rb_pc", bus.pc, 32'h1000);
    cycle();
    @(negedge clk_in);
    check("rb_req", 32'(bus.fetch_start), 32'd1);
    check("rb_req_pc", bus.pc, 32'h1000);
    cycle();

    // five-cycle pause in the middle of a WAIT with finish_fetch held high
    k_pop_pct = 100;
    pause_req = 1'b1;
    repeat (40) step();
    check("pause_taken", 32'(n_pauses), 32'd1);

    // asynchronous reset mid-WAIT with entries queued
    k_pop_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = (m_q.size() >= 3) && m_req;
    end
    check("arst_setup", 32'(found), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("arst_fetch_start", 32'(bus.fetch_start), 32'd0);
    check("arst_pc", bus.pc, RST_PC);
    check("arst_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("arst_queue_full", 32'(queue_full), 32'd0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    cycle();

    // random program region, random pauses, stalls, stale finishes and roll_backs
    for (int a = 0; a < 512; a++) begin
      rnd = $urandom_range(99);
      w   = $urandom;
      if (rnd < 55)      w = NOP;
      else if (rnd < 70) w = {w[31:7], 7'b1100011};
      else if (rnd < 80) w = {w[31:7], 7'b1100111};
      else               w = {w[31:7], 7'b1101111};
      mem[32'h2000 + 32'(a) * 4] = w;
    end
    k_rdy_pct   = 85;
    k_rb_permil = 20;
    k_stale_pct = 10;
    for (int blk = 0; blk < 6; blk++) begin
      k_pop_pct = (blk % 2 == 0) ? 90 : 5;
      repeat (500) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
